// File: rtl/elink_trig_pkg.sv
// Shared types and bus widths for the elink trigger scrubber read controller.
package elink_trig_pkg;
  localparam int WB_ADDR_W = 4;
  localparam int WB_DATA_W = 12;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;
  typedef enum logic {HOST, SCAN} owner_t;
endpackage

// File: rtl/elink_trig_scrub_ctrl_if.sv
// Wishbone-style port to the scrubber register bank: stb/stall request, ack/data response.
interface elink_trig_scrub_ctrl_if;
  import elink_trig_pkg::*;

  logic [WB_ADDR_W-1:0] o_wb_addr;
  logic                 o_wb_stb;
  logic [WB_DATA_W-1:0] i_wb_data;
  logic                 i_wb_ack;
  logic                 i_wb_stall;

  modport master (output o_wb_addr, o_wb_stb, input i_wb_data, i_wb_ack, i_wb_stall);
  modport slave  (input o_wb_addr, o_wb_stb, output i_wb_data, i_wb_ack, i_wb_stall);
endinterface

// File: rtl/elink_scan_timer.sv
// Periodic scan trigger: period down-counter, pending flag and scan address pointer.
module elink_scan_timer
  import elink_trig_pkg::*;
#(
  parameter int N_ADDR      = 16,
  parameter int SCAN_PERIOD = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_scan_en,
  input  logic                 i_txn_done,
  output logic                 o_pending,
  output logic [WB_ADDR_W-1:0] o_addr,
  output logic                 o_last
);
  localparam int CW = $clog2(SCAN_PERIOD);
  localparam logic [CW-1:0]        RELOAD = CW'(SCAN_PERIOD - 1);
  localparam logic [WB_ADDR_W-1:0] LAST_A = WB_ADDR_W'(N_ADDR - 1);

  logic [CW-1:0]        r_cnt;
  logic                 r_pending;
  logic [WB_ADDR_W-1:0] r_ptr;
  logic                 w_last;

  assign w_last = (r_ptr == LAST_A);

  always_ff @(posedge clk) begin
    if (rst || !i_scan_en) begin
      r_cnt     <= RELOAD;
      r_pending <= 1'b0;
      r_ptr     <= '0;
    end else begin
      // An expiry while a scan is still pending is dropped, never queued.
      if (r_cnt == '0) begin
        r_cnt <= RELOAD;
        if (!r_pending) r_pending <= 1'b1;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Completions of a transaction left over from a disabled scan are ignored.
      if (i_txn_done && r_pending) begin
        if (w_last) begin
          r_ptr     <= '0;
          r_pending <= 1'b0;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end
    end
  end

  assign o_pending = r_pending;
  assign o_addr    = r_ptr;
  assign o_last    = w_last;
endmodule

// File: rtl/elink_trig_scrub_ctrl.sv
// Arbitrates host reads and periodic scan reads onto the single scrubber port,
// with a per-transaction timeout and saturating timeout counter.
module elink_trig_scrub_ctrl
  import elink_trig_pkg::*;
#(
  parameter int N_ADDR      = 16,
  parameter int SCAN_PERIOD = 1024,
  parameter int TIMEOUT     = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_scan_en,
  input  logic                 i_host_req,
  input  logic [WB_ADDR_W-1:0] i_host_addr,
  output logic                 o_host_gnt,
  output logic                 o_host_valid,
  output logic [WB_DATA_W-1:0] o_host_data,
  output logic                 o_host_err,
  output logic                 o_scan_valid,
  output logic [WB_ADDR_W-1:0] o_scan_addr,
  output logic [WB_DATA_W-1:0] o_scan_data,
  output logic                 o_scan_done,
  output logic [7:0]           o_timeout_cnt,
  elink_trig_scrub_ctrl_if.master wb
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  state_t               r_state;
  owner_t               r_owner;
  logic [WB_ADDR_W-1:0] r_addr;
  logic                 r_stb;
  logic [TW-1:0]        r_tmr;
  logic                 r_host_gnt;
  logic                 r_host_valid;
  logic [WB_DATA_W-1:0] r_host_data;
  logic                 r_host_err;
  logic                 r_scan_valid;
  logic [WB_ADDR_W-1:0] r_scan_addr;
  logic [WB_DATA_W-1:0] r_scan_data;
  logic                 r_scan_done;
  logic [7:0]           r_timeout_cnt;

  logic                 w_ack_ok;
  logic                 w_tmo;
  logic                 w_scan_txn_done;
  logic                 w_pending;
  logic                 w_last;
  logic [WB_ADDR_W-1:0] w_scan_ptr;

  // Ack only counts in WAIT_ACK, and it beats a timeout firing on the same edge.
  assign w_ack_ok        = (r_state == WAIT_ACK) && wb.i_wb_ack;
  assign w_tmo           = (r_state != IDLE) && (r_tmr == TMR_LAST) && !w_ack_ok;
  assign w_scan_txn_done = (r_owner == SCAN) && (w_ack_ok || w_tmo);

  elink_scan_timer #(
    .N_ADDR      (N_ADDR),
    .SCAN_PERIOD (SCAN_PERIOD)
  ) u_scan_timer (
    .clk        (clk),
    .rst        (rst),
    .i_scan_en  (i_scan_en),
    .i_txn_done (w_scan_txn_done),
    .o_pending  (w_pending),
    .o_addr     (w_scan_ptr),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_owner       <= HOST;
      r_addr        <= '0;
      r_stb         <= 1'b0;
      r_tmr         <= '0;
      r_host_gnt    <= 1'b0;
      r_host_valid  <= 1'b0;
      r_host_data   <= '0;
      r_host_err    <= 1'b0;
      r_scan_valid  <= 1'b0;
      r_scan_addr   <= '0;
      r_scan_data   <= '0;
      r_scan_done   <= 1'b0;
      r_timeout_cnt <= '0;
    end else begin
      r_host_gnt   <= 1'b0;
      r_host_valid <= 1'b0;
      r_host_err   <= 1'b0;
      r_scan_valid <= 1'b0;
      r_scan_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tmr <= '0;
          if (i_host_req) begin
            r_addr     <= i_host_addr;
            r_owner    <= HOST;
            r_host_gnt <= 1'b1;
            r_stb      <= 1'b1;
            r_state    <= ISSUE;
          end else if (w_pending) begin
            r_addr  <= w_scan_ptr;
            r_owner <= SCAN;
            r_stb   <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE, WAIT_ACK: begin
          if (w_tmo) begin
            r_stb   <= 1'b0;
            r_state <= IDLE;
            if (r_timeout_cnt != 8'hFF) r_timeout_cnt <= r_timeout_cnt + 8'd1;
            if (r_owner == HOST) r_host_err <= 1'b1;
            else                 r_scan_done <= w_last && w_pending;
          end else begin
            r_tmr <= r_tmr + 1'b1;
            if ((r_state == ISSUE) && !wb.i_wb_stall) begin
              r_stb   <= 1'b0;
              r_state <= WAIT_ACK;
            end
            if (w_ack_ok) begin
              r_state <= IDLE;
              if (r_owner == HOST) begin
                r_host_valid <= 1'b1;
                r_host_data  <= wb.i_wb_data;
              end else begin
                r_scan_valid <= 1'b1;
                r_scan_addr  <= r_addr;
                r_scan_data  <= wb.i_wb_data;
                r_scan_done  <= w_last && w_pending;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wb.o_wb_addr  = r_addr;
  assign wb.o_wb_stb   = r_stb;
  assign o_host_gnt    = r_host_gnt;
  assign o_host_valid  = r_host_valid;
  assign o_host_data   = r_host_data;
  assign o_host_err    = r_host_err;
  assign o_scan_valid  = r_scan_valid;
  assign o_scan_addr   = r_scan_addr;
  assign o_scan_data   = r_scan_data;
  assign o_scan_done   = r_scan_done;
  assign o_timeout_cnt = r_timeout_cnt;
endmodule
